// File: rtl/transmit_psk_dac.sv
// PSK/CW transmitter: NCO phase accumulator plus symbol phase offset, sine LUT,
// formatted into a registered DAC sample. Symbols come from an internal PRBS-7 or an external port.
module transmit_psk_dac #(
  parameter int BIT_DAC    = 14,
  parameter int PHASE_W    = 32,
  parameter int LUT_BITS   = 8,
  parameter int SYM_DIV    = 50,
  parameter int OFFSET_BIN = 1
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic               src_sel,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [1:0]         sym_in,
  input  logic               sym_valid,
  output logic               sym_ready,
  output logic               sym_strobe,
  output logic               underflow,
  output logic [BIT_DAC-1:0] DAC_OUT,
  output logic               PLL_OUT_DA,
  output logic               DA_WRTA,
  output logic               DA_MODE
);

  localparam int LUT_N = 1 << LUT_BITS;
  localparam int CNT_W = $clog2(SYM_DIV);
  localparam longint PI_FX = 64'sd3373259426;
  localparam logic [1:0] MODE_IDLE = 2'b00;
  localparam logic [1:0] MODE_BPSK = 2'b01;
  localparam logic [1:0] MODE_QPSK = 2'b10;
  localparam logic [1:0] MODE_CW   = 2'b11;
  localparam logic [BIT_DAC-1:0] ZERO_CODE =
    (OFFSET_BIN != 0) ? {1'b1, {(BIT_DAC-1){1'b0}}} : {BIT_DAC{1'b0}};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state, state_next;
  logic                       active, boundary, ext_src;
  logic [CNT_W-1:0]           cnt;
  logic [PHASE_W-1:0]         acc;
  logic [6:0]                 prbs, prbs_next;
  logic                       bit_hi, bit_lo;
  logic [1:0]                 new_sym;
  logic [2:0]                 new_off, sym_off;
  logic                       sym_live, live1;
  logic [LUT_BITS-1:0]        ph1;
  logic signed [BIT_DAC-1:0]  lut_q;
  logic signed [BIT_DAC-1:0]  lut [LUT_N];

  // Elaboration-time sine: Taylor series in 2^30 fixed point over the first
  // quadrant, mirrored into the other three, rounded to the DAC amplitude.
  function automatic logic signed [BIT_DAC-1:0] sine_entry(input int k);
    longint x, x2, term, sum, amp, mag;
    int h, j;
    logic [BIT_DAC-1:0] v;
    h = k % (LUT_N / 2);
    j = (h <= LUT_N / 4) ? h : (LUT_N / 2 - h);
    x = (longint'(j) * PI_FX) >>> (LUT_BITS - 1);
    x2 = (x * x) >>> 30;
    term = x;
    sum = x;
    for (int n = 1; n < 10; n++) begin
      term = -((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1));
      sum = sum + term;
    end
    amp = (longint'(1) <<< (BIT_DAC - 1)) - 1;
    mag = (amp * sum + (longint'(1) <<< 29)) >>> 30;
    v = mag[BIT_DAC-1:0];
    return (k >= LUT_N / 2) ? -v : v;
  endfunction

  for (genvar k = 0; k < LUT_N; k++) begin : g_lut
    localparam logic signed [BIT_DAC-1:0] VAL = sine_entry(k);
    assign lut[k] = VAL;
  end

  assign PLL_OUT_DA = CLOCK_50;
  assign DA_WRTA    = ~CLOCK_50;
  assign DA_MODE    = 1'b1;

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = (mode == MODE_IDLE) ? IDLE : RUN;
  end

  // mode 00 already counts as inactive in the cycle before IDLE is entered,
  // so every datapath register clears on that same edge.
  always_comb begin
    active    = (state == RUN) && (mode != MODE_IDLE);
    boundary  = active && (cnt == CNT_W'(SYM_DIV - 1));
    ext_src   = src_sel && ((mode == MODE_BPSK) || (mode == MODE_QPSK));
    sym_ready = boundary && ext_src;
  end

  always_comb begin
    bit_hi    = prbs[6] ^ prbs[5];
    bit_lo    = prbs[5] ^ prbs[4];
    prbs_next = {prbs[5:0], bit_hi};
    new_sym   = {1'b0, bit_hi};
    if (mode == MODE_QPSK) begin
      prbs_next = {prbs[4:0], bit_hi, bit_lo};
      new_sym   = {bit_hi, bit_lo};
    end
    if (src_sel) new_sym = sym_in;
    new_off = 3'd0;
    case (mode)
      MODE_BPSK: new_off = new_sym[0] ? 3'd4 : 3'd0;
      MODE_QPSK: begin
        case (new_sym)
          2'b00:   new_off = 3'd1;
          2'b01:   new_off = 3'd3;
          2'b11:   new_off = 3'd5;
          default: new_off = 3'd7;
        endcase
      end
      default:   new_off = 3'd0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      acc <= '0;
    end else if (!active) begin
      cnt <= '0;
      acc <= '0;
    end else begin
      cnt <= boundary ? '0 : cnt + CNT_W'(1);
      acc <= acc + freq_word;
    end
  end

  // A missing external symbol mutes the whole period instead of repeating the last one.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      prbs       <= 7'h7F;
      sym_off    <= 3'd0;
      sym_live   <= 1'b0;
      sym_strobe <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      sym_strobe <= 1'b0;
      if (!active) begin
        sym_off  <= 3'd0;
        sym_live <= 1'b0;
      end else if (boundary) begin
        if (ext_src && !sym_valid) begin
          sym_live  <= 1'b0;
          underflow <= 1'b1;
        end else begin
          sym_off    <= new_off;
          sym_live   <= 1'b1;
          sym_strobe <= 1'b1;
          if (!src_sel && (mode != MODE_CW)) prbs <= prbs_next;
        end
      end
    end
  end

  // Only the top LUT_BITS of accumulator+offset are kept; the offset has no
  // lower bits, so no carry is lost by adding at the truncated width.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      ph1     <= '0;
      live1   <= 1'b0;
      lut_q   <= '0;
      DAC_OUT <= ZERO_CODE;
    end else if (!active) begin
      ph1     <= '0;
      live1   <= 1'b0;
      lut_q   <= '0;
      DAC_OUT <= ZERO_CODE;
    end else begin
      ph1     <= acc[PHASE_W-1 -: LUT_BITS] + (LUT_BITS'(sym_off) << (LUT_BITS - 3));
      live1   <= sym_live;
      lut_q   <= live1 ? lut[ph1] : '0;
      DAC_OUT <= (OFFSET_BIN != 0) ? {~lut_q[BIT_DAC-1], lut_q[BIT_DAC-2:0]} : lut_q;
    end
  end

endmodule

// File: tb/tb_transmit_psk_dac.sv
// Directed bench for transmit_psk_dac: one offset-binary and one two's-complement
// instance share the same stimulus; expected codes are hand-computed.
module tb_transmit_psk_dac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = 2'b00;
  logic        src_sel = 1'b0;
  logic [31:0] freq_word = '0;
  logic [1:0]  sym_in = 2'b00;
  logic        sym_valid = 1'b0;

  logic        sym_ready, sym_strobe, underflow;
  logic [13:0] dac;
  logic        pll_out, da_wrta, da_mode;
  logic        tc_ready, tc_strobe, tc_underflow;
  logic [13:0] dac_tc;
  logic        tc_pll, tc_wrta, tc_mode;

  int checks = 0;
  int errors = 0;
  int n;
  int exp_sym [4];

  always #10 clk = ~clk;

  transmit_psk_dac #(.BIT_DAC(14), .PHASE_W(32), .LUT_BITS(8), .SYM_DIV(50), .OFFSET_BIN(1)) dut (
    .CLOCK_50(clk), .reset(reset), .mode(mode), .src_sel(src_sel), .freq_word(freq_word),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(sym_ready), .sym_strobe(sym_strobe),
    .underflow(underflow), .DAC_OUT(dac), .PLL_OUT_DA(pll_out), .DA_WRTA(da_wrta), .DA_MODE(da_mode)
  );

  transmit_psk_dac #(.BIT_DAC(14), .PHASE_W(32), .LUT_BITS(8), .SYM_DIV(50), .OFFSET_BIN(0)) dut_tc (
    .CLOCK_50(clk), .reset(reset), .mode(mode), .src_sel(src_sel), .freq_word(freq_word),
    .sym_in(sym_in), .sym_valid(sym_valid), .sym_ready(tc_ready), .sym_strobe(tc_strobe),
    .underflow(tc_underflow), .DAC_OUT(dac_tc), .PLL_OUT_DA(tc_pll), .DA_WRTA(tc_wrta), .DA_MODE(tc_mode)
  );

  task automatic checkOutput(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic s, input logic [31:0] fw);
    mode      = m;
    src_sel   = s;
    freq_word = fw;
  endtask

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  // which = 0 waits for sym_strobe, 1 for sym_ready; cycles counts negedges waited.
  task automatic waitFor(input bit which, input int limit, input string tag, output int cycles);
    logic hit;
    cycles = 0;
    hit = 1'b0;
    while (!hit && cycles < limit) begin
      @(negedge clk);
      cycles++;
      hit = which ? sym_ready : sym_strobe;
    end
    if (!hit) checkOutput(tag, 0, 1);
  endtask

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_sym = '{13984, 13984, 13984, 2400};
    applyStimulus(2'b10, 1'b0, 32'd0);
    step(3);
    checkOutput("rst_dac", int'(dac), 8192);
    checkOutput("rst_dac_tc", int'($signed(dac_tc)), 0);
    checkOutput("rst_strobe", int'(sym_strobe), 0);
    checkOutput("rst_ready", int'(sym_ready), 0);
    checkOutput("rst_underflow", int'(underflow), 0);
    checkOutput("pll_out_da", int'(pll_out), 0);
    checkOutput("da_wrta", int'(da_wrta), 1);
    checkOutput("da_mode", int'(da_mode), 1);

    // Internal PRBS QPSK: symbols 00,00,00,10 from the 7F seed.
    reset = 1'b0;
    waitFor(1'b0, 60, "first_strobe_timeout", n);
    checkOutput("first_strobe_latency", n, 51);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        waitFor(1'b0, 60, "strobe_timeout", n);
        checkOutput("strobe_period", n + 3, 50);
      end
      step(1);
      if (k == 0) checkOutput("strobe_width", int'(sym_strobe), 0);
      step(1);
      if (k == 3) checkOutput("qpsk_prbs_latency", int'(dac), 13984);
      step(1);
      checkOutput("qpsk_prbs_sym", int'(dac), exp_sym[k]);
    end

    applyStimulus(2'b00, 1'b0, 32'd0);
    step(1);
    checkOutput("idle_dac", int'(dac), 8192);
    checkOutput("idle_ready", int'(sym_ready), 0);

    // CW at a quarter-cycle per clock; first live sample carries phase 50*fw.
    applyStimulus(2'b11, 1'b0, 32'h4000_0000);
    step(54);
    checkOutput("cw_s0", int'(dac), 8192);
    step(1);
    checkOutput("cw_s1", int'(dac), 1);
    checkOutput("cw_s1_tc", int'($signed(dac_tc)), -8191);
    step(1);
    checkOutput("cw_s2", int'(dac), 8192);
    step(1);
    checkOutput("cw_s3", int'(dac), 16383);
    step(1);
    checkOutput("cw_s4", int'(dac), 8192);
    step(1);
    checkOutput("cw_s5", int'(dac), 1);

    applyStimulus(2'b00, 1'b0, 32'd0);
    step(2);

    // External QPSK symbols 11, 01, then a missing symbol, then 11 again.
    sym_valid = 1'b1;
    sym_in    = 2'b11;
    applyStimulus(2'b10, 1'b1, 32'd0);
    waitFor(1'b1, 60, "ready_timeout", n);
    step(1);
    checkOutput("ready_width", int'(sym_ready), 0);
    checkOutput("ext_strobe", int'(sym_strobe), 1);
    sym_in = 2'b01;
    step(3);
    checkOutput("ext_qpsk_11", int'(dac), 2400);
    checkOutput("ext_qpsk_11_tc", int'($signed(dac_tc)), -5792);
    waitFor(1'b1, 60, "ready_timeout", n);
    checkOutput("ready_period", n + 4, 50);
    step(1);
    sym_valid = 1'b0;
    step(3);
    checkOutput("ext_qpsk_01", int'(dac), 13984);
    waitFor(1'b1, 60, "ready_timeout", n);
    checkOutput("underflow_before", int'(underflow), 0);
    step(1);
    checkOutput("underflow_set", int'(underflow), 1);
    step(3);
    checkOutput("underflow_dac", int'(dac), 8192);
    step(20);
    checkOutput("underflow_hold_dac", int'(dac), 8192);
    checkOutput("underflow_sticky", int'(underflow), 1);
    sym_valid = 1'b1;
    sym_in    = 2'b11;
    waitFor(1'b1, 60, "ready_timeout", n);
    step(4);
    checkOutput("resume_dac", int'(dac), 2400);
    checkOutput("resume_underflow", int'(underflow), 1);

    // BPSK external symbol 1 takes effect at the next boundary.
    applyStimulus(2'b01, 1'b1, 32'd0);
    sym_in = 2'b01;
    waitFor(1'b1, 60, "ready_timeout", n);
    step(4);
    checkOutput("bpsk_180_dac", int'(dac), 8192);
    checkOutput("bpsk_180_tc", int'($signed(dac_tc)), 0);

    // Reset mid-symbol, then restart with a freshly seeded PRBS.
    applyStimulus(2'b10, 1'b0, 32'd0);
    step(10);
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_dac", int'(dac), 8192);
    checkOutput("rst_mid_underflow", int'(underflow), 0);
    checkOutput("rst_mid_strobe", int'(sym_strobe), 0);
    checkOutput("rst_mid_ready", int'(sym_ready), 0);
    step(2);
    reset = 1'b0;
    waitFor(1'b0, 60, "restart_timeout", n);
    checkOutput("restart_latency", n, 51);
    step(3);
    checkOutput("restart_sym", int'(dac), 13984);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
